// File: rtl/ysyx_2022040010_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stage bit positions, FSM states,
// and the canned hold/bubble vectors the sequencer drives.
package ysyx_2022040010_ctrl_pkg;

  localparam int unsigned STG_W     = 5;
  localparam int unsigned STG_PC    = 0;
  localparam int unsigned STG_IF_ID = 1;
  localparam int unsigned STG_ID_EX = 2;
  localparam int unsigned STG_EX_MEM = 3;
  localparam int unsigned STG_MEM_WB = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Bit order: [4]=mem_wb [3]=ex_mem [2]=id_ex [1]=if_id [0]=pc
  localparam logic [STG_W-1:0] STALL_NONE  = 5'b00000;
  localparam logic [STG_W-1:0] STALL_MEM   = 5'b01111;
  localparam logic [STG_W-1:0] STALL_EX    = 5'b00111;
  localparam logic [STG_W-1:0] STALL_ID    = 5'b00011;
  localparam logic [STG_W-1:0] STALL_IF    = 5'b00001;
  localparam logic [STG_W-1:0] FLUSH_NONE  = 5'b00000;
  localparam logic [STG_W-1:0] FLUSH_MEM   = 5'b10000;
  localparam logic [STG_W-1:0] FLUSH_EX    = 5'b01000;
  localparam logic [STG_W-1:0] FLUSH_ID    = 5'b00100;
  localparam logic [STG_W-1:0] FLUSH_IF    = 5'b00010;
  localparam logic [STG_W-1:0] FLUSH_REDIR = 5'b00110;
  localparam logic [STG_W-1:0] FLUSH_TRAP  = 5'b11110;

endpackage

// File: rtl/ysyx_2022040010_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles (saturating) and raises a
// sticky timeout once the count reaches the limit.
module ysyx_2022040010_stall_wdog #(
  parameter int unsigned STALL_LIMIT = 1023,
  parameter int unsigned WD_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic any_stall,
  output logic timeout
);

  logic [WD_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  // Count clears on any free-flowing cycle; holds once at the limit.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (any_stall) begin
      if (cnt_q == WD_W'(STALL_LIMIT)) cnt_d = cnt_q;
      else                             cnt_d = cnt_q + WD_W'(1);
    end
    if (cnt_d == WD_W'(STALL_LIMIT)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/ysyx_2022040010_pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, branch redirects and traps
// into per-register hold/bubble vectors and the pc_reg override.
module ysyx_2022040010_pipe_ctrl
  import ysyx_2022040010_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 64,
  parameter int unsigned STALL_LIMIT = 1023,
  parameter int unsigned WD_W        = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_if,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  input  logic            stallreq_mem,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_pc,
  output logic [4:0]      stall,
  output logic [4:0]      flush,
  output logic            new_pc_valid,
  output logic [PC_W-1:0] new_pc,
  output logic            redir_pending,
  output logic            stall_timeout,
  output logic [31:0]     stall_cycles
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic [STG_W-1:0]  req_stall, req_flush;
  logic [STG_W-1:0]  stall_c, flush_c;
  logic              npc_valid_c;
  logic [PC_W-1:0]   npc_c;
  logic              dstall;
  logic              any_stall;

  assign dstall = stallreq_ex | stallreq_mem;

  // Latest stage holding wins; it holds everything upstream and bubbles itself.
  always_comb begin
    req_stall = STALL_NONE;
    req_flush = FLUSH_NONE;
    if (stallreq_mem) begin
      req_stall = STALL_MEM;
      req_flush = FLUSH_MEM;
    end else if (stallreq_ex) begin
      req_stall = STALL_EX;
      req_flush = FLUSH_EX;
    end else if (stallreq_id) begin
      req_stall = STALL_ID;
      req_flush = FLUSH_ID;
    end else if (stallreq_if) begin
      req_stall = STALL_IF;
      req_flush = FLUSH_IF;
    end
  end

  // Trap beats redirect; a redirect blocked by EX/MEM is parked until they free up.
  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    stall_c     = req_stall;
    flush_c     = req_flush;
    npc_valid_c = 1'b0;
    npc_c       = '0;
    if (trap_valid) begin
      stall_c     = STALL_NONE;
      flush_c     = FLUSH_TRAP;
      npc_valid_c = 1'b1;
      npc_c       = trap_pc;
      state_d     = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (redirect_valid) begin
            if (!dstall) begin
              stall_c     = STALL_NONE;
              flush_c     = FLUSH_REDIR;
              npc_valid_c = 1'b1;
              npc_c       = redirect_pc;
            end else begin
              pend_pc_d = redirect_pc;
              state_d   = ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (!dstall) begin
            stall_c     = STALL_NONE;
            flush_c     = FLUSH_REDIR;
            npc_valid_c = 1'b1;
            npc_c       = pend_pc_q;
            state_d     = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
    if (!rst) begin
      stall_c     = STALL_NONE;
      flush_c     = FLUSH_NONE;
      npc_valid_c = 1'b0;
      npc_c       = '0;
    end
  end

  assign any_stall = |stall_c;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (any_stall && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      pend_pc_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_pc_q      <= pend_pc_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  ysyx_2022040010_stall_wdog #(
    .STALL_LIMIT (STALL_LIMIT),
    .WD_W        (WD_W)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .any_stall (any_stall),
    .timeout   (stall_timeout)
  );

  assign stall         = stall_c;
  assign flush         = flush_c;
  assign new_pc_valid  = npc_valid_c;
  assign new_pc        = npc_c;
  assign redir_pending = (state_q == ST_PEND) && rst;
  assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_ysyx_2022040010_pipe_ctrl.sv
// Scoreboard bench for the pipeline sequencer: the driver applies one vector per
// cycle and queues its expected response; a negedge monitor pops and compares.
module tb_ysyx_2022040010_pipe_ctrl;

  localparam int unsigned PC_W = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic            redirect_valid, trap_valid;
  logic [PC_W-1:0] redirect_pc, trap_pc;
  logic [4:0]      stall, flush;
  logic            new_pc_valid, redir_pending, stall_timeout;
  logic [PC_W-1:0] new_pc;
  logic [31:0]     stall_cycles;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string           name;
    logic [4:0]      stall;
    logic [4:0]      flush;
    logic            npv;
    logic [PC_W-1:0] npc;
    logic            pend;
    logic [31:0]     cyc;
    logic            tmo;
  } exp_t;

  exp_t exp_q[$];

  ysyx_2022040010_pipe_ctrl #(
    .PC_W        (PC_W),
    .STALL_LIMIT (4),
    .WD_W        (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .stall          (stall),
    .flush          (flush),
    .new_pc_valid   (new_pc_valid),
    .new_pc         (new_pc),
    .redir_pending  (redir_pending),
    .stall_timeout  (stall_timeout),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field,
                     input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", name, field, act, want);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "stall",         64'(stall),         64'(e.stall));
      chk(e.name, "flush",         64'(flush),         64'(e.flush));
      chk(e.name, "new_pc_valid",  64'(new_pc_valid),  64'(e.npv));
      chk(e.name, "new_pc",        new_pc,             e.npc);
      chk(e.name, "redir_pending", 64'(redir_pending), 64'(e.pend));
      chk(e.name, "stall_cycles",  64'(stall_cycles),  64'(e.cyc));
      chk(e.name, "stall_timeout", 64'(stall_timeout), 64'(e.tmo));
    end
  end

  // One cycle of stimulus: {rst,if,id,ex,mem}, redirect, trap, then expectations.
  task automatic vec(input string name, input logic [4:0] ctl,
                     input logic rv, input logic [63:0] rpc,
                     input logic tv, input logic [63:0] tpc,
                     input logic [4:0] es, input logic [4:0] ef,
                     input logic enpv, input logic [63:0] enpc,
                     input logic epend, input logic [31:0] ecyc, input logic etmo);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = ctl[4];
    stallreq_if    = ctl[3];
    stallreq_id    = ctl[2];
    stallreq_ex    = ctl[1];
    stallreq_mem   = ctl[0];
    redirect_valid = rv;
    redirect_pc    = rpc;
    trap_valid     = tv;
    trap_pc        = tpc;
    e.name = name; e.stall = es; e.flush = ef; e.npv = enpv; e.npc = enpc;
    e.pend = epend; e.cyc = ecyc; e.tmo = etmo;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    redirect_valid = 0; redirect_pc = '0; trap_valid = 0; trap_pc = '0;
    repeat (2) @(posedge clk);

    //   name          rst,if,id,ex,mem  rv rpc            tv tpc            stall     flush     npv npc           pend cyc tmo
    vec("reset",        5'b00000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 0, 0);
    vec("idle",         5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 0, 0);
    vec("id_req",       5'b10100, 0, 64'h0,          0, 64'h0,          5'b00011, 5'b00100, 0, 64'h0,          0, 0, 0);
    vec("idle_cnt1",    5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 1, 0);
    vec("ex_over_if",   5'b11010, 0, 64'h0,          0, 64'h0,          5'b00111, 5'b01000, 0, 64'h0,          0, 1, 0);
    vec("mem_req",      5'b10001, 0, 64'h0,          0, 64'h0,          5'b01111, 5'b10000, 0, 64'h0,          0, 2, 0);
    vec("if_req",       5'b11000, 0, 64'h0,          0, 64'h0,          5'b00001, 5'b00010, 0, 64'h0,          0, 3, 0);
    vec("redir_now",    5'b10100, 1, 64'h8000_0040,  0, 64'h0,          5'b00000, 5'b00110, 1, 64'h8000_0040,  0, 4, 0);
    vec("redir_park",   5'b10001, 1, 64'h8000_0100,  0, 64'h0,          5'b01111, 5'b10000, 0, 64'h0,          0, 4, 0);
    vec("pend_1",       5'b10001, 1, 64'h8000_0100,  0, 64'h0,          5'b01111, 5'b10000, 0, 64'h0,          1, 5, 0);
    vec("pend_ignore",  5'b10001, 1, 64'hDEAD_0000,  0, 64'h0,          5'b01111, 5'b10000, 0, 64'h0,          1, 6, 0);
    vec("pend_release", 5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00110, 1, 64'h8000_0100,  1, 7, 0);
    vec("back_run",     5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 7, 0);
    vec("park_ex",      5'b10010, 1, 64'h100,        0, 64'h0,          5'b00111, 5'b01000, 0, 64'h0,          0, 7, 0);
    vec("trap_in_pend", 5'b10010, 0, 64'h0,          1, 64'h8000_0000,  5'b00000, 5'b11110, 1, 64'h8000_0000,  1, 8, 0);
    vec("post_trap",    5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 8, 0);
    vec("post_trap2",   5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 8, 0);
    vec("trap_over_mem",5'b10001, 0, 64'h0,          1, 64'h1234,       5'b00000, 5'b11110, 1, 64'h1234,       0, 8, 0);
    vec("wd_1",         5'b11000, 0, 64'h0,          0, 64'h0,          5'b00001, 5'b00010, 0, 64'h0,          0, 8, 0);
    vec("wd_2",         5'b11000, 0, 64'h0,          0, 64'h0,          5'b00001, 5'b00010, 0, 64'h0,          0, 9, 0);
    vec("wd_3",         5'b11000, 0, 64'h0,          0, 64'h0,          5'b00001, 5'b00010, 0, 64'h0,          0, 10, 0);
    vec("wd_4",         5'b11000, 0, 64'h0,          0, 64'h0,          5'b00001, 5'b00010, 0, 64'h0,          0, 11, 0);
    vec("wd_5",         5'b11000, 0, 64'h0,          0, 64'h0,          5'b00001, 5'b00010, 0, 64'h0,          0, 12, 1);
    vec("wd_6",         5'b11000, 0, 64'h0,          0, 64'h0,          5'b00001, 5'b00010, 0, 64'h0,          0, 13, 1);
    vec("wd_sticky",    5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 14, 1);
    vec("rst_mid",      5'b01000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 0, 0);
    vec("rst_release",  5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 0, 0);
    vec("park_pre_rst", 5'b10010, 1, 64'h55,         0, 64'h0,          5'b00111, 5'b01000, 0, 64'h0,          0, 0, 0);
    vec("rst_in_pend",  5'b00010, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 0, 0);
    vec("pend_lost",    5'b10000, 0, 64'h0,          0, 64'h0,          5'b00000, 5'b00000, 0, 64'h0,          0, 0, 0);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL drain got=%0d want=0 pending expectations", exp_q.size());
      end
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_pipe_ctrl.md
Name: ysyx_2022040010_pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV64 core. It collects per-stage stall requests, the EX branch/jump redirect and the MEM trap request. It drives the per-register hold (stall) and bubble (flush) vectors for pc_reg, if_id, id_ex, ex_mem and mem_wb, plus the next-PC override into pc_reg. It holds a redirect that cannot retire under a downstream stall, and it runs a stall watchdog and a stall-cycle counter for debug.

Parameters:
PC_W, 64, width of the PC and redirect/trap target
STALL_LIMIT, 1023, consecutive stalled cycles before stall_timeout sets
WD_W, 10, watchdog counter width; must satisfy STALL_LIMIT < 2**WD_W

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
stallreq_if  in  1  fetch not ready
stallreq_id  in  1  load-use hazard in ID
stallreq_ex  in  1  multi-cycle EX op busy
stallreq_mem  in  1  data memory wait
redirect_valid  in  1  EX resolved a taken branch/jump
redirect_pc  in  PC_W  redirect target
trap_valid  in  1  MEM raised a trap
trap_pc  in  PC_W  trap vector
stall  out  5  hold; bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb
flush  out  5  bubble insert, same bit order
new_pc_valid  out  1  pc_reg loads new_pc this cycle
new_pc  out  PC_W  PC override value
redir_pending  out  1  state == PEND
stall_timeout  out  1  sticky watchdog flag
stall_cycles  out  32  saturating count of cycles with stall != 0

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, pend_pc=0, watchdog=0, stall_cycles=0, stall_timeout=0. All combinational outputs read 0.
- The stall/flush vectors are combinational from inputs and state. The latest-stage request wins:
  - stallreq_mem: stall=01111, flush=10000.
  - else stallreq_ex: stall=00111, flush=01000.
  - else stallreq_id: stall=00011, flush=00100.
  - else stallreq_if: stall=00001, flush=00010.
  - else both vectors are 0.
- "dstall" means stallreq_ex | stallreq_mem.
- FSM states: RUN and PEND.
- Priority 1, trap: when trap_valid=1 in any state:
  - stall=00000, flush=11110, new_pc_valid=1, new_pc=trap_pc.
  - Next state is RUN; any pending redirect is discarded.
- Priority 2, redirect in RUN:
  - redirect_valid=1 and dstall=0: apply in the same cycle. stall=00000 (the IF/ID stall requests are wrong-path and are overridden), flush=00110, new_pc_valid=1, new_pc=redirect_pc. State stays RUN.
  - redirect_valid=1 and dstall=1: capture pend_pc<=redirect_pc and go to PEND. The stall vector follows the normal request table; new_pc_valid=0.
- PEND:
  - redirect_valid is ignored, because EX re-presents the same branch while held.
  - While dstall=1: normal stall table, new_pc_valid=0.
  - On the first cycle with dstall=0: stall=00000, flush=00110, new_pc_valid=1, new_pc=pend_pc, next state RUN.
- new_pc is 0 whenever new_pc_valid=0.
- Watchdog:
  - Increments on each cycle with stall!=0 and clears on any cycle with stall==0; it saturates at STALL_LIMIT.
  - stall_timeout sets on the cycle after the counter reaches STALL_LIMIT. It stays set until reset and has no effect on the pipeline.
- stall_cycles increments on each cycle with stall!=0 and saturates at 0xFFFF_FFFF.
- Reset mid-PEND: the pending redirect is lost and the state is RUN when rst deasserts.

Decomposition:
- Package ysyx_2022040010_ctrl_pkg: stage bit indices (PC=0..MEM_WB=4), state encoding (RUN, PEND), constant vectors (STALL_MEM=5'b01111, FLUSH_REDIR=5'b00110, FLUSH_TRAP=5'b11110, etc.).
- Sub-module ysyx_2022040010_stall_wdog: the saturating watchdog counter plus the sticky flag. Its inputs are clk, rst, any_stall; its output is timeout.

Test Plan:
- stallreq_id=1 for 1 cycle, others 0 -> stall=00011, flush=00100; stall_cycles 0->1.
- stallreq_ex=1 and stallreq_if=1 together -> stall=00111, flush=01000 (EX wins).
- RUN, redirect_valid=1, redirect_pc=0x8000_0040, stallreq_id=1 -> same cycle new_pc_valid=1, new_pc=0x8000_0040, stall=00000, flush=00110.
- redirect_valid=1 (pc=0x8000_0100) with stallreq_mem=1 for 3 cycles -> redir_pending=1 for 3 cycles with new_pc_valid=0. On the 4th cycle, mem stall drops: new_pc=0x8000_0100, flush=00110, state RUN.
- In PEND (pend_pc=0x100), trap_valid=1, trap_pc=0x8000_0000 -> new_pc=0x8000_0000, flush=11110. The next cycle is RUN and 0x100 is never issued.
- STALL_LIMIT=4, stallreq_if held 6 cycles -> stall_timeout rises after the 4th stalled cycle and stays 1 after the stall ends. Assert rst=0 mid-test -> all outputs 0 immediately.
